fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO (WIDTH×DEPTH, pointer/toggle-flag full/empty) among NREQ producers. Each producer holds a request plus data; the arbiter grants one owner at a time for a bounded burst and drives the FIFO write port. Writes are throttled by the FIFO full flag, and FIFO write errors are flagged. It sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types, defaults and helpers for the FIFO write arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Default configuration
    localparam int WIDTH_DEF = 8;
    localparam int NREQ_DEF  = 4;
    localparam int BURST_DEF = 4;

    // Width of an index able to address n items (never less than 1 bit)
    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches last+1, last+2, ...
//               modulo NREQ and returns the first requesting index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   last,
    output logic            any,
    output logic [PW-1:0]   idx
);

    logic [NREQ-1:0] w_rot;
    logic [PW-1:0]   w_off;
    logic            w_found;

    // Rotate so the slot after 'last' sits at bit 0, priority-encode, un-rotate
    always_comb begin
        w_rot   = '0;
        w_off   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = req[PW'((int'(last) + 1 + i) % NREQ)];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_rot[i] && !w_found) begin
                w_found = 1'b1;
                w_off   = PW'(i);
            end
        end
        any = |req;
        idx = PW'((int'(last) + 1 + int'(w_off)) % NREQ);
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin write arbiter sharing one FIFO write port among
//               NREQ producers, with bounded bursts, full throttling and a
//               sticky write-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int NREQ  = NREQ_DEF,
    parameter  int BURST = BURST_DEF,
    localparam int PW    = ptr_w(NREQ),
    localparam int BW    = ptr_w(BURST)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] wdata_i,
    output logic [NREQ-1:0]       ack_o,
    input  logic                  fifo_full_i,
    input  logic                  fifo_wr_error_i,
    output logic                  fifo_wr_en_o,
    output logic [WIDTH-1:0]      fifo_wdata_o,
    output logic                  gnt_valid_o,
    output logic [PW-1:0]         gnt_id_o,
    output logic                  ovf_err_o,
    output logic [15:0]           wr_count_o
);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     last_q,  last_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              ovf_q,   ovf_d;
    logic [15:0]       cnt_q,   cnt_d;

    logic              w_any;
    logic [PW-1:0]     w_pick;
    logic              w_wr;
    logic [WIDTH-1:0]  w_data [NREQ];

    // Split the flat data bus into one word per requester
    genvar gk;
    generate
        for (gk = 0; gk < NREQ; gk++) begin : g_unpack
            assign w_data[gk] = wdata_i[gk*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req  (req_i),
        .last (last_q),
        .any  (w_any),
        .idx  (w_pick)
    );

    // A write happens only while granted, the owner still requests, and there is room
    assign w_wr = (state_q == ST_GRANT) && req_i[owner_q] && !fifo_full_i;

    // Write-port outputs: ack is one-hot on the owner, data always follows the owner
    always_comb begin
        ack_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            ack_o[k] = w_wr && (owner_q == PW'(k));
        end
        fifo_wr_en_o = w_wr;
        fifo_wdata_o = w_data[owner_q];
    end

    // Next-state logic for the grant FSM and its counters
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        ovf_d   = ovf_q | fifo_wr_error_i;
        cnt_d   = cnt_q + {15'd0, w_wr};
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    owner_d = w_pick;
                    last_d  = w_pick;
                    burst_d = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req_i[owner_q]) begin
                    // Owner withdrew: release without writing
                    state_d = ST_IDLE;
                    burst_d = '0;
                end else if (!fifo_full_i) begin
                    if (burst_q == BW'(BURST - 1)) begin
                        state_d = ST_IDLE;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BW'(1);
                    end
                end
                // Full stall: hold everything, stalls do not consume burst slots
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset; requester 0 wins first
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= PW'(NREQ - 1);
            burst_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_valid_o = (state_q == ST_GRANT);
    assign gnt_id_o    = owner_q;
    assign ovf_err_o   = ovf_q;
    assign wr_count_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter (8x4, BURST 4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [3:0]  req_i;
    logic [31:0] wdata_i;
    logic [3:0]  ack_o;
    logic        fifo_full_i;
    logic        fifo_wr_error_i;
    logic        fifo_wr_en_o;
    logic [7:0]  fifo_wdata_o;
    logic        gnt_valid_o;
    logic [1:0]  gnt_id_o;
    logic        ovf_err_o;
    logic [15:0] wr_count_o;

    int n_cmp = 0;
    int n_err = 0;

    // Per-requester data: base value plus number of words already accepted
    logic [7:0] base [4] = '{8'hA0, 8'h10, 8'h50, 8'hC0};
    logic [7:0] dcnt [4] = '{8'd0, 8'd0, 8'd0, 8'd0};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .WIDTH (8),
        .NREQ  (4),
        .BURST (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_i           (req_i),
        .wdata_i         (wdata_i),
        .ack_o           (ack_o),
        .fifo_full_i     (fifo_full_i),
        .fifo_wr_error_i (fifo_wr_error_i),
        .fifo_wr_en_o    (fifo_wr_en_o),
        .fifo_wdata_o    (fifo_wdata_o),
        .gnt_valid_o     (gnt_valid_o),
        .gnt_id_o        (gnt_id_o),
        .ovf_err_o       (ovf_err_o),
        .wr_count_o      (wr_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_data();
        for (int k = 0; k < 4; k++) begin
            wdata_i[k*8 +: 8] = base[k] + dcnt[k];
        end
    endtask

    // One clock cycle: drive just after posedge, check outputs at negedge
    task automatic cyc(input string tag, input logic rst, input logic [3:0] req,
                       input logic full, input logic err, input logic [3:0] eack,
                       input logic egv, input logic [1:0] eid);
        logic [7:0] edata;
        @(posedge clk);
        #1;
        rst_ni          = rst;
        req_i           = req;
        fifo_full_i     = full;
        fifo_wr_error_i = err;
        drive_data();
        @(negedge clk);
        edata = base[eid] + dcnt[eid];
        chk({tag, ".ack"},   32'(ack_o),        32'(eack));
        chk({tag, ".wren"},  32'(fifo_wr_en_o), 32'(eack != 4'd0));
        chk({tag, ".gnt"},   32'(gnt_valid_o),  32'(egv));
        chk({tag, ".id"},    32'(gnt_id_o),     32'(eid));
        chk({tag, ".wdata"}, 32'(fifo_wdata_o), 32'(edata));
        if (eack != 4'd0) dcnt[eid] = dcnt[eid] + 8'd1;
    endtask

    initial begin
        rst_ni          = 1'b0;
        req_i           = 4'hF;
        fifo_full_i     = 1'b0;
        fifo_wr_error_i = 1'b0;
        drive_data();

        // Reset with every requester asserting
        cyc("rst", 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        chk("rst.ovf",   32'(ovf_err_o),  32'd0);
        chk("rst.count", 32'(wr_count_o), 32'd0);

        // Single owner: two bursts of four separated by one idle cycle
        cyc("so_c1", 1'b1, 4'b0001, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        repeat (4) cyc("so_b1", 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);
        cyc("so_c6", 1'b1, 4'b0001, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        repeat (4) cyc("so_b2", 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);
        cyc("so_end", 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        chk("so.count", 32'(wr_count_o), 32'd8);

        // Rotation with all requesting: owners 0,1,2,3,0
        cyc("rot_rst",  1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        cyc("rot_idle", 1'b1, 4'hF,    1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        for (int o = 0; o < 5; o++) begin
            logic [1:0] own;
            own = 2'(o % 4);
            repeat (4) cyc("rot_w", 1'b1, 4'hF, 1'b0, 1'b0, 4'b0001 << own, 1'b1, own);
            if (o < 4) cyc("rot_b", 1'b1, 4'hF,    1'b0, 1'b0, 4'h0, 1'b0, own);
            else       cyc("rot_b", 1'b1, 4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, own);
        end
        chk("rot.count", 32'(wr_count_o), 32'd20);

        // Full stall on owner 2 does not consume burst slots
        cyc("st_w1", 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2);
        repeat (3) cyc("st_full", 1'b1, 4'b0100, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2);
        repeat (3) cyc("st_w", 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2);
        cyc("st_end", 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2);
        chk("st.count", 32'(wr_count_o), 32'd24);

        // Sticky write error
        cyc("err_p", 1'b1, 4'b0000, 1'b0, 1'b1, 4'h0, 1'b0, 2'd2);
        chk("err.same_cycle", 32'(ovf_err_o), 32'd0);
        cyc("err_n", 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2);
        chk("err.next", 32'(ovf_err_o), 32'd1);
        repeat (20) cyc("err_hold", 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2);
        chk("err.held", 32'(ovf_err_o), 32'd1);
        cyc("err_rst",  1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2);
        cyc("err_post", 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        chk("err.cleared",  32'(ovf_err_o),  32'd0);
        chk("err.count0",   32'(wr_count_o), 32'd0);

        // Mid-burst reset: owner 1 after two writes, then requester 0 wins
        cyc("mb_req", 1'b1, 4'b0010, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        repeat (2) cyc("mb_w", 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1);
        cyc("mb_rst",  1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1);
        cyc("mb_idle", 1'b1, 4'b0011, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
        chk("mb.count", 32'(wr_count_o), 32'd0);
        cyc("mb_g0",   1'b1, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);
        cyc("mb_g0b",  1'b1, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);
        chk("mb.count1", 32'(wr_count_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
